tlb_assoc: RTL and testbench

Parametrised fully-associative TLB that translates the fetch address (port 0) and the data address (port 1) in the same cycle they are presented. It sits between the pipeline's fetch/memory stages and physical memory. Compared with the fixed 8-entry TLB it adds:
- configurable depth and widths;
- per-entry permission and global bits, with protection faults;
- in-place update of an existing mapping;
- invalid-first replacement;
- single-cycle selective invalidation by PID or by VA.

---
 rtl/tlb_assoc.sv | 168 ++++++++++++++++
 tb/tb_tlb_assoc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_assoc.sv
// Fully-associative TLB with two combinational translation ports, a lookup port keyed by wr_key,
// in-place update, invalid-first / round-robin replacement and PID/VA selective invalidation.
module tlb_assoc #(
    parameter int          ENTRIES      = 8,
    parameter int          PID_W        = 12,
    parameter int          VPN_W        = 20,
    parameter int          PAGE_W       = 12,
    parameter int          PPN_W        = 6,
    parameter logic [31:0] BYPASS_LIMIT = 32'h30000,
    localparam int         PA_W         = PPN_W + PAGE_W,
    localparam int         DATA_W       = PPN_W + 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              kmode,
    input  logic [PID_W-1:0]  pid,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic              acc1_wr,
    input  logic              acc1_en,
    input  logic [7:0]        exc_in,
    input  logic              we,
    input  logic [31:0]       wr_key,
    input  logic [31:0]       wr_data,
    input  logic              inv_all,
    input  logic              inv_pid,
    input  logic              inv_va,
    output logic [PA_W-1:0]   addr0_out,
    output logic [PA_W-1:0]   addr1_out,
    output logic [7:0]        exc_out0,
    output logic [7:0]        exc_out1,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int BIT_R = PPN_W;
    localparam int BIT_W = PPN_W + 1;
    localparam int BIT_X = PPN_W + 2;
    localparam int BIT_U = PPN_W + 3;
    localparam int BIT_G = PPN_W + 4;

    logic              valid_reg [ENTRIES];
    logic [31:0]       key_reg   [ENTRIES];
    logic [DATA_W-1:0] data_reg  [ENTRIES];
    logic [IDX_W-1:0]  rr_reg;

    logic [ENTRIES-1:0] valid_vec, hit0, hit1, hit_rd, exact, kill;
    logic [PID_W-1:0]   wr_pid;
    logic [VPN_W-1:0]   wr_vpn;
    logic               inv_sel;
    logic               wr_commit;
    logic [IDX_W-1:0]   wr_idx;
    logic               use_rr;
    logic               unused_ok;

    assign wr_pid    = wr_key[31:VPN_W];
    assign wr_vpn    = wr_key[VPN_W-1:0];
    assign inv_sel   = inv_pid || inv_va;
    assign wr_commit = we && !inv_all && !inv_sel;
    assign unused_ok = ^wr_data[31:DATA_W];

    // Lowest set index; callers qualify with a separate any-bit.
    function automatic logic [IDX_W-1:0] first_set(input logic [ENTRIES-1:0] v);
        first_set = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) first_set = IDX_W'(i);
        end
    endfunction

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ent
        logic [VPN_W-1:0] e_vpn;
        logic [PID_W-1:0] e_pid;
        logic             e_g;

        assign e_vpn = key_reg[gi][VPN_W-1:0];
        assign e_pid = key_reg[gi][31:VPN_W];
        assign e_g   = data_reg[gi][BIT_G];

        assign valid_vec[gi] = valid_reg[gi];
        assign hit0[gi]   = valid_reg[gi] && (e_vpn == addr0[PAGE_W +: VPN_W]) && ((e_pid == pid) || e_g);
        assign hit1[gi]   = valid_reg[gi] && (e_vpn == addr1[PAGE_W +: VPN_W]) && ((e_pid == pid) || e_g);
        assign hit_rd[gi] = valid_reg[gi] && (e_vpn == wr_vpn) && ((e_pid == wr_pid) || e_g);
        // In-place update ignores G: only the exact {pid, vpn} key is the same mapping.
        assign exact[gi]  = valid_reg[gi] && (key_reg[gi] == wr_key);
        assign kill[gi]   = (inv_pid && !e_g && (e_pid == wr_pid))
                         || (inv_va && (e_vpn == wr_vpn) && ((e_pid == wr_pid) || e_g));

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
            end else if (clk_en) begin
                if (inv_all) begin
                    valid_reg[gi] <= 1'b0;
                end else if (inv_sel) begin
                    if (kill[gi]) valid_reg[gi] <= 1'b0;
                end else if (we && (wr_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                    key_reg[gi]   <= wr_key;
                    data_reg[gi]  <= wr_data[DATA_W-1:0];
                end
            end
        end
    end

    always_comb begin
        wr_idx = rr_reg;
        use_rr = 1'b0;
        if (|exact) begin
            wr_idx = first_set(exact);
        end else if (|(~valid_vec)) begin
            wr_idx = first_set(~valid_vec);
        end else begin
            use_rr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg <= '0;
        end else if (clk_en && wr_commit && use_rr) begin
            rr_reg <= rr_reg + IDX_W'(1);
        end
    end

    // Translation ports
    logic [DATA_W-1:0] d0, d1;
    logic              byp0, byp1, flt0, flt1;
    logic [7:0]        miss_code, exc0, exc1;

    assign miss_code = kmode ? 8'h83 : 8'h82;
    assign d0   = data_reg[first_set(hit0)];
    assign d1   = data_reg[first_set(hit1)];
    assign byp0 = kmode && (addr0 < BYPASS_LIMIT);
    assign byp1 = kmode && (addr1 < BYPASS_LIMIT);
    assign flt0 = !d0[BIT_X] || (!kmode && !d0[BIT_U]);
    assign flt1 = (acc1_en && (acc1_wr ? !d1[BIT_W] : !d1[BIT_R])) || (!kmode && !d1[BIT_U]);

    always_comb begin
        exc0 = 8'h00;
        if (!byp0) begin
            if (!(|hit0))  exc0 = miss_code;
            else if (flt0) exc0 = 8'h84;
        end
        exc1 = 8'h00;
        if (exc_in != 8'h00) begin
            exc1 = exc_in;
        end else if (!byp1) begin
            if (!(|hit1))  exc1 = miss_code;
            else if (flt1) exc1 = 8'h84;
        end
    end

    always_comb begin
        if (byp0)               addr0_out = addr0[PA_W-1:0];
        else if (exc0 != 8'h00) addr0_out = '0;
        else                    addr0_out = {d0[PPN_W-1:0], addr0[PAGE_W-1:0]};

        if (exc1 != 8'h00)      addr1_out = PA_W'({exc1, 2'b00});
        else if (byp1)          addr1_out = addr1[PA_W-1:0];
        else                    addr1_out = {d1[PPN_W-1:0], addr1[PAGE_W-1:0]};
    end

    assign exc_out0 = exc0;
    assign exc_out1 = exc1;
    assign rd_hit   = |hit_rd;
    assign rd_data  = rd_hit ? data_reg[first_set(hit_rd)] : '0;
endmodule

// File: tb/tb_tlb_assoc.sv
// Self-checking bench for tlb_assoc: directed scenarios plus randomized traffic, all compared
// against a simple array-based reference model of the translation rules.
module tb_tlb_assoc;
    localparam int ENTRIES = 8;
    localparam int PA_W    = 18;
    localparam logic [31:0] BYPASS_LIMIT = 32'h30000;

    logic        clk = 1'b0;
    logic        rst, clk_en, kmode, acc1_wr, acc1_en, we, inv_all, inv_pid, inv_va;
    logic [11:0] pid;
    logic [31:0] addr0, addr1, wr_key, wr_data;
    logic [7:0]  exc_in;
    logic [PA_W-1:0] addr0_out, addr1_out;
    logic [7:0]  exc_out0, exc_out1;
    logic        rd_hit;
    logic [10:0] rd_data;

    tlb_assoc dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .kmode(kmode), .pid(pid),
        .addr0(addr0), .addr1(addr1), .acc1_wr(acc1_wr), .acc1_en(acc1_en),
        .exc_in(exc_in), .we(we), .wr_key(wr_key), .wr_data(wr_data),
        .inv_all(inv_all), .inv_pid(inv_pid), .inv_va(inv_va),
        .addr0_out(addr0_out), .addr1_out(addr1_out), .exc_out0(exc_out0),
        .exc_out1(exc_out1), .rd_hit(rd_hit), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit          m_valid [ENTRIES];
    logic [31:0] m_key   [ENTRIES];
    logic [10:0] m_data  [ENTRIES];
    int          m_rr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int m_find(input logic [11:0] p, input logic [19:0] vpn);
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_key[i][19:0] == vpn && (m_key[i][31:20] == p || m_data[i][10]))
                return i;
        return -1;
    endfunction

    function automatic void m_translate(input int port, input logic [31:0] a,
                                        output logic [7:0] e, output logic [PA_W-1:0] pa);
        bit byp = kmode && (a < BYPASS_LIMIT);
        int idx = m_find(pid, a[31:12]);
        logic [10:0] d = (idx >= 0) ? m_data[idx] : 11'h0;
        bit fault = (!kmode && !d[9]) || (port == 0 && !d[8])
                 || (port == 1 && acc1_en && (acc1_wr ? !d[7] : !d[6]));
        e = 8'h00;
        if (port == 1 && exc_in != 8'h00) e = exc_in;
        else if (!byp && idx < 0)         e = kmode ? 8'h83 : 8'h82;
        else if (!byp && fault)           e = 8'h84;
        if (e != 8'h00) pa = (port == 1) ? PA_W'(e * 4) : '0;
        else if (byp)   pa = a[PA_W-1:0];
        else            pa = PA_W'(d[5:0] * 4096 + a[11:0]);
    endfunction

    task automatic check_outputs();
        logic [7:0] e;
        logic [PA_W-1:0] pa;
        int idx;
        m_translate(0, addr0, e, pa);
        check("exc_out0", exc_out0, e);
        check("addr0_out", addr0_out, pa);
        m_translate(1, addr1, e, pa);
        check("exc_out1", exc_out1, e);
        check("addr1_out", addr1_out, pa);
        idx = m_find(wr_key[31:20], wr_key[19:0]);
        check("rd_hit", rd_hit, idx >= 0);
        check("rd_data", rd_data, (idx >= 0) ? m_data[idx] : 11'h0);
    endtask

    task automatic model_commit();
        int t;
        if (rst) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_rr = 0;
        end else if (clk_en) begin
            if (inv_all) begin
                foreach (m_valid[i]) m_valid[i] = 0;
            end else if (inv_pid || inv_va) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    bit g = m_data[i][10];
                    bit same_pid = m_key[i][31:20] == wr_key[31:20];
                    if ((inv_pid && !g && same_pid) ||
                        (inv_va && m_key[i][19:0] == wr_key[19:0] && (same_pid || g)))
                        m_valid[i] = 0;
                end
            end else if (we) begin
                t = -1;
                for (int i = ENTRIES - 1; i >= 0; i--) if (m_valid[i] && m_key[i] == wr_key) t = i;
                if (t < 0) for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) t = i;
                if (t < 0) begin
                    t = m_rr;
                    m_rr = (m_rr + 1) % ENTRIES;
                end
                m_valid[t] = 1;
                m_key[t]   = wr_key;
                m_data[t]  = wr_data[10:0];
            end
        end
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
    task automatic do_cycle(input bit chk);
        @(negedge clk);
        if (chk) check_outputs();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        rst = 0; clk_en = 1; we = 0; inv_all = 0; inv_pid = 0; inv_va = 0;
        acc1_en = 0; acc1_wr = 0; exc_in = 0;
    endtask

    task automatic write(input logic [11:0] p, input logic [19:0] vpn, input logic [31:0] d);
        wr_key = {p, vpn}; wr_data = d; we = 1;
        do_cycle(1);
        we = 0;
    endtask

    function automatic logic [31:0] perm(input int ppn, input bit r, w, x, u, g);
        return 32'(ppn) | (32'(r) << 6) | (32'(w) << 7) | (32'(x) << 8) | (32'(u) << 9) | (32'(g) << 10);
    endfunction

    initial begin
        idle();
        rst = 1; kmode = 0; pid = 0; addr0 = 0; addr1 = 0; wr_key = 0; wr_data = 0;
        do_cycle(0);
        rst = 0;

        // After reset: user miss, then kernel bypass
        kmode = 0; pid = 5; addr0 = 32'h0001_2345; addr1 = 32'h0001_2345; #2;
        check("reset_exc0", exc_out0, 8'h82);
        check("reset_pa0", addr0_out, 0);
        check("reset_rd_hit", rd_hit, 0);
        do_cycle(1);
        kmode = 1; addr0 = 32'h0002_1234; #2;
        check("bypass_pa0", addr0_out, 32'h21234);
        check("bypass_exc0", exc_out0, 0);
        do_cycle(1);

        // Basic translation and store protection fault
        kmode = 0;
        write(12'd5, 20'h00012, perm(3, 1, 0, 1, 1, 0));
        addr0 = 32'h0001_2ABC; addr1 = 32'h0001_2ABC; acc1_en = 1; acc1_wr = 1; #2;
        check("hit_pa0", addr0_out, 32'h03ABC);
        check("hit_exc0", exc_out0, 0);
        check("store_fault_exc1", exc_out1, 8'h84);
        check("store_fault_pa1", addr1_out, 32'h210);
        do_cycle(1);
        acc1_en = 0; acc1_wr = 0;

        // Fill, round-robin replacement, in-place rewrite
        rst = 1; do_cycle(1); rst = 0;
        pid = 2;
        for (int i = 0; i < ENTRIES; i++) write(12'd2, 20'h100 + 20'(i), perm(i, 1, 1, 1, 1, 0));
        write(12'd2, 20'h200, perm(9, 1, 1, 1, 1, 0));
        wr_key = {12'd2, 20'h100}; #2;
        check("rr_victim0_gone", rd_hit, 0);
        do_cycle(1);
        write(12'd2, 20'h102, perm(6'h2A, 1, 1, 1, 1, 0));
        addr0 = 32'h0010_2000; #2;
        check("inplace_pa0", addr0_out, 32'h2A000);
        do_cycle(1);
        write(12'd2, 20'h300, perm(4, 1, 1, 1, 1, 0));
        wr_key = {12'd2, 20'h101}; #2;
        check("rr_victim1_gone", rd_hit, 0);
        do_cycle(1);
        wr_key = {12'd2, 20'h102}; #2;
        check("inplace_kept", rd_hit, 1);
        do_cycle(1);

        // Global entries survive inv_pid; inv_all clears all
        rst = 1; do_cycle(1); rst = 0;
        write(12'd1, 20'h40, perm(7, 1, 1, 1, 1, 1));
        write(12'd1, 20'h41, perm(8, 1, 1, 1, 1, 0));
        wr_key = {12'd1, 20'h0}; inv_pid = 1; do_cycle(1); inv_pid = 0;
        pid = 7; addr0 = 32'h0004_0000; wr_key = {12'd1, 20'h41}; #2;
        check("global_kept_pa0", addr0_out, 32'h07000);
        check("nonglobal_gone", rd_hit, 0);
        do_cycle(1);
        inv_all = 1; do_cycle(1); inv_all = 0;
        #2;
        check("inv_all_exc0", exc_out0, 8'h82);
        do_cycle(1);

        // we dropped under inv_va; exc_in priority; clk_en hold
        write(12'd3, 20'h50, perm(1, 1, 1, 1, 1, 0));
        wr_key = {12'd3, 20'h50}; we = 1; inv_va = 1; do_cycle(1); we = 0; inv_va = 0;
        #2;
        check("inv_va_drops_we", rd_hit, 0);
        pid = 3; addr1 = 32'h0009_9000; exc_in = 8'h10; #1;
        check("exc_in_exc1", exc_out1, 8'h10);
        check("exc_in_pa1", addr1_out, 32'h40);
        do_cycle(1);
        exc_in = 0;
        clk_en = 0; wr_key = {12'd3, 20'h60}; wr_data = perm(2, 1, 1, 1, 1, 0); we = 1;
        do_cycle(1);
        we = 0; clk_en = 1; #2;
        check("clk_en_hold", rd_hit, 0);
        do_cycle(1);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            idle();
            rst     = ($urandom_range(0, 99) == 0);
            clk_en  = ($urandom_range(0, 9) != 0);
            kmode   = $urandom_range(0, 1);
            pid     = 12'($urandom_range(1, 3));
            addr0   = {12'h0, 8'($urandom_range(0, 1) ? 8'h40 : 8'h10) + 8'($urandom_range(0, 3)), 12'($urandom)};
            addr1   = {12'h0, 8'($urandom_range(0, 1) ? 8'h40 : 8'h10) + 8'($urandom_range(0, 3)), 12'($urandom)};
            acc1_en = $urandom_range(0, 1);
            acc1_wr = $urandom_range(0, 1);
            exc_in  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h0;
            wr_key  = {12'($urandom_range(1, 3)),
                       20'($urandom_range(0, 1) ? 20'h40 : 20'h10) + 20'($urandom_range(0, 3))};
            wr_data = $urandom;
            we      = ($urandom_range(0, 9) < 4);
            inv_all = ($urandom_range(0, 59) == 0);
            inv_pid = ($urandom_range(0, 24) == 0);
            inv_va  = ($urandom_range(0, 19) == 0);
            do_cycle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
